octree_cmd_dispatcher: RTL and testbench

Front-end command queue that sits directly upstream of the octree controller. It buffers host octree operations (SEARCH / ADD / DEL plus a payload word) in a FIFO and issues them one at a time on the controller's ctrl bus. After each issue it waits for the matching done pulse from the searcher or updater before issuing the next command. It also holds the active command's payload stable for the updater and runs a per-command watchdog.

---
 rtl/octree_cmd_dispatcher.sv | 158 +++++++++++++++
 tb/tb_octree_cmd_dispatcher.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/octree_cmd_dispatcher.sv
// Command queue in front of the octree controller: buffers host ops, issues one at a time on ctrl.
// Latency: push into empty queue while idle -> pop next edge -> ctrl valid for one cycle after that.
// Backpressure: cmd_ready = registered fifo_count < FIFO_DEPTH; next issue waits for matching done or watchdog.
module octree_cmd_dispatcher #(
  parameter int CONTROL_WIDTH  = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [DATA_WIDTH-1:0]         cmd_data,
  input  logic                          flush,
  output logic [CONTROL_WIDTH-1:0]      ctrl,
  output logic [DATA_WIDTH-1:0]         op_data,
  input  logic                          search_done,
  input  logic                          add_done,
  input  logic                          del_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  // Queue storage is not reset; the pointers and count define what is valid.
  logic [1:0]            mem_op   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];

  logic [1:0]               state_q, state_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [1:0]               cur_op_q, cur_op_d;
  logic [DATA_WIDTH-1:0]    op_data_q, op_data_d;
  logic [CONTROL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [WD_W-1:0]          wd_q, wd_d;
  logic                     timeout_err_q, timeout_err_d;

  logic push, pop, match_done, timeout_hit;

  assign cmd_ready   = (count_q < CNT_W'(FIFO_DEPTH));
  assign fifo_count  = count_q;
  assign ctrl        = ctrl_q;
  assign op_data     = op_data_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != ST_IDLE) || (count_q != '0);

  // Handshake qualification: op 0 is swallowed, flush drops a same-edge push and blocks the pop.
  always_comb begin
    push = cmd_valid && cmd_ready && (cmd_op != 2'd0) && !flush;
    pop  = (state_q == ST_IDLE) && (count_q != '0) && !flush;
    case (cur_op_q)
      2'd1:    match_done = search_done;
      2'd2:    match_done = add_done;
      2'd3:    match_done = del_done;
      default: match_done = 1'b0;
    endcase
  end

  // Next-state for the queue pointers/count, FSM, watchdog and output registers.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    state_d       = state_q;
    cur_op_d      = cur_op_q;
    op_data_d     = op_data_q;
    wd_d          = wd_q;
    timeout_hit   = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
    end else if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          cur_op_d  = mem_op[rd_ptr_q];
          op_data_d = mem_data[rd_ptr_q];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A done on the final watchdog cycle still counts as success.
        if (match_done) begin
          state_d = ST_IDLE;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh timeout is recorded even if flush clears the old flag on the same edge.
    timeout_err_d = (timeout_err_q && !flush) || timeout_hit;
    ctrl_d        = (state_d == ST_ISSUE) ? CONTROL_WIDTH'(cur_op_d) : '0;
  end

  // Queue storage write.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr_q]   <= cmd_op;
      mem_data[wr_ptr_q] <= cmd_data;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cur_op_q      <= '0;
      op_data_q     <= '0;
      ctrl_q        <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      cur_op_q      <= cur_op_d;
      op_data_q     <= op_data_d;
      ctrl_q        <= ctrl_d;
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_octree_cmd_dispatcher.sv
// Directed bench for octree_cmd_dispatcher (FIFO_DEPTH=8, TIMEOUT_CYCLES=16).
// Inputs change 1 time unit after a rising edge; outputs are checked at that point.
// Expected values are hand-derived from the cycle behaviour of the dispatcher.
module tb_octree_cmd_dispatcher;

  localparam int CW = 8;
  localparam int DW = 32;
  localparam int FD = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [DW-1:0] cmd_data = '0;
  logic          flush = 1'b0;
  logic [CW-1:0] ctrl;
  logic [DW-1:0] op_data;
  logic          search_done = 1'b0;
  logic          add_done = 1'b0;
  logic          del_done = 1'b0;
  logic          busy;
  logic [3:0]    fifo_count;
  logic          timeout_err;

  int err_cnt = 0;
  int chk_cnt = 0;

  octree_cmd_dispatcher #(
    .CONTROL_WIDTH(CW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .flush(flush), .ctrl(ctrl),
    .op_data(op_data), .search_done(search_done), .add_done(add_done),
    .del_done(del_done), .busy(busy), .fifo_count(fifo_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
  endtask

  // which: 1=search_done, 2=add_done, 3=del_done
  task automatic pulse(input int which);
    search_done = (which == 1);
    add_done    = (which == 2);
    del_done    = (which == 3);
    tick();
    search_done = 1'b0;
    add_done    = 1'b0;
    del_done    = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2;
    check("rst_ctrl", ctrl, 0);
    check("rst_op_data", op_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_ready", cmd_ready, 1);

    // ---------------- 1: single SEARCH ----------------
    push(2'd1, 32'hA5);
    check("t1_count_after_push", fifo_count, 1);
    check("t1_ctrl_before_issue", ctrl, 0);
    check("t1_busy", busy, 1);
    tick();
    check("t1_ctrl_issue", ctrl, 1);
    check("t1_op_data", op_data, 32'hA5);
    check("t1_count_after_pop", fifo_count, 0);
    tick();
    check("t1_ctrl_one_cycle", ctrl, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_ctrl_wait", ctrl, 0);
    end
    pulse(1);
    check("t1_busy_done", busy, 0);
    check("t1_count_done", fifo_count, 0);
    check("t1_op_data_held", op_data, 32'hA5);

    // ---------------- 2: back-to-back ----------------
    push(2'd2, 32'h10);
    push(2'd3, 32'h20);
    check("t2_ctrl_add", ctrl, 2);
    check("t2_op_data_add", op_data, 32'h10);
    push(2'd1, 32'h30);
    check("t2_ctrl_wait", ctrl, 0);
    check("t2_count2", fifo_count, 2);
    pulse(1);
    check("t2_stray_ctrl", ctrl, 0);
    check("t2_stray_count", fifo_count, 2);
    check("t2_stray_busy", busy, 1);
    pulse(2);
    check("t2_idle_ctrl", ctrl, 0);
    tick();
    check("t2_ctrl_del", ctrl, 3);
    check("t2_op_data_del", op_data, 32'h20);
    check("t2_count1", fifo_count, 1);
    tick();
    pulse(3);
    tick();
    check("t2_ctrl_search", ctrl, 1);
    check("t2_op_data_search", op_data, 32'h30);
    check("t2_count0", fifo_count, 0);
    tick();
    pulse(1);
    check("t2_busy_end", busy, 0);

    // ---------------- 3: full FIFO ----------------
    push(2'd2, 32'h100);
    tick();
    for (int i = 0; i < 8; i++) push(2'd2, 32'h200 + i);
    check("t3_count_full", fifo_count, 8);
    check("t3_ready_low", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_data  = 32'h208;
    tick();
    check("t3_ninth_held", fifo_count, 8);
    add_done = 1'b1;
    tick();
    add_done = 1'b0;
    check("t3_count_at_done", fifo_count, 8);
    tick();
    check("t3_count_after_pop", fifo_count, 7);
    check("t3_ready_high", cmd_ready, 1);
    check("t3_ctrl_pop", ctrl, 2);
    check("t3_op_data_pop", op_data, 32'h200);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    check("t3_count_refill", fifo_count, 8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_flush_count", fifo_count, 0);
    pulse(2);
    check("t3_busy_end", busy, 0);

    // ---------------- 4: timeout ----------------
    push(2'd2, 32'h40);
    push(2'd1, 32'h50);
    check("t4_ctrl_add", ctrl, 2);
    for (int i = 0; i < TO; i++) tick();
    check("t4_no_err_yet", timeout_err, 0);
    tick();
    check("t4_timeout_err", timeout_err, 1);
    check("t4_ctrl_idle", ctrl, 0);
    check("t4_busy_queued", busy, 1);
    tick();
    check("t4_next_issue", ctrl, 1);
    check("t4_next_op_data", op_data, 32'h50);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_flush_clears_err", timeout_err, 0);
    pulse(1);
    check("t4_busy_end", busy, 0);

    // ---------------- 5: invalid op and flush ----------------
    push(2'd0, 32'h77);
    check("t5_inv_count", fifo_count, 0);
    check("t5_inv_busy", busy, 0);
    tick();
    check("t5_inv_ctrl", ctrl, 0);
    push(2'd2, 32'h60);
    push(2'd1, 32'h61);
    push(2'd3, 32'h62);
    push(2'd2, 32'h63);
    check("t5_count3", fifo_count, 3);
    flush     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_data  = 32'h64;
    tick();
    flush     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    check("t5_flush_count", fifo_count, 0);
    check("t5_active_busy", busy, 1);
    pulse(2);
    check("t5_done_busy", busy, 0);
    check("t5_done_op_data", op_data, 32'h60);
    tick();
    check("t5_no_issue", ctrl, 0);

    // ---------------- 6: reset mid-operation ----------------
    push(2'd3, 32'h90);
    push(2'd1, 32'h91);
    push(2'd1, 32'h92);
    push(2'd2, 32'h93);
    push(2'd3, 32'h94);
    check("t6_count4", fifo_count, 4);
    check("t6_op_data_pre", op_data, 32'h90);
    rst_n = 1'b0;
    #1;
    check("t6_async_ctrl", ctrl, 0);
    check("t6_async_count", fifo_count, 0);
    check("t6_async_op_data", op_data, 0);
    check("t6_async_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_issue", ctrl, 0);
    end
    check("t6_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
